// File: rtl/neuron_sched.sv
// Time-multiplexed accumulate-and-fire scheduler sharing one adder across CHANNELS neurons.
// Optional leaky update enabled by defining NEURON_SCHED_LEAK_EN.
module neuron_sched #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_addr,
    input  logic [WIDTH-1:0]    cfg_w,
    input  logic [CHANNELS-1:0] chan_en,
    output logic                spike_valid,
    output logic [CH_W-1:0]     spike_ch,
    input  logic                spike_ready,
    output logic                busy,
    output logic                sweep_done,
    output logic                overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   ptr;
    logic [WIDTH-1:0]  pot [CHANNELS];
    logic [WIDTH-1:0]  wt  [CHANNELS];
    logic              stall, proc, last, en, fire, cfg_ok;
    logic [WIDTH-1:0]  base;
    logic [WIDTH:0]    acc;

    assign last   = (ptr == CH_W'(CHANNELS - 1));
    assign cfg_ok = (32'(cfg_addr) < CHANNELS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick) state_nx = RUN;
            RUN:     if (proc && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        sweep_done = (state == DONE);
        stall      = spike_valid & ~spike_ready;
        proc       = (state == RUN) & ~stall;
    end

    // Single shared datapath: operands are whatever channel ptr selects.
    always_comb begin
        en   = chan_en[ptr];
`ifdef NEURON_SCHED_LEAK_EN
        base = pot[ptr] - (pot[ptr] >> 3);
`else
        base = pot[ptr];
`endif
        acc  = {1'b0, base} + {1'b0, wt[ptr]};
        fire = proc & en & acc[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (state != RUN) begin
            ptr <= '0;
        end else if (proc && !last) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pot[i] <= '0;
                wt[i]  <= '0;
            end
        end else begin
            if (proc && en) pot[ptr] <= acc[WIDTH-1:0];
            if (cfg_we && cfg_ok) wt[cfg_addr] <= cfg_w;
        end
    end

    // A new spike in the transfer cycle simply reloads the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_valid <= 1'b0;
            spike_ch    <= '0;
        end else if (fire) begin
            spike_valid <= 1'b1;
            spike_ch    <= ptr;
        end else if (spike_valid && spike_ready) begin
            spike_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              overrun <= 1'b0;
        else if (tick && busy) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_neuron_sched.sv
// Directed self-checking bench for neuron_sched (CHANNELS=4, WIDTH=8).
module tb_neuron_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_w;
    logic [3:0] chan_en;
    logic       spike_valid;
    logic [1:0] spike_ch;
    logic       spike_ready;
    logic       busy;
    logic       sweep_done;
    logic       overrun;

    int checks = 0;
    int fails  = 0;

    neuron_sched #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w(cfg_w),
        .chan_en(chan_en),
        .spike_valid(spike_valid), .spike_ch(spike_ch),
        .spike_ready(spike_ready),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] w);
        cfg_we = 1'b1; cfg_addr = a; cfg_w = w;
        step();
        cfg_we = 1'b0;
    endtask

    // Pulses tick and watches the sweep; c=1 is the first busy cycle.
    task automatic do_sweep(output int nsp, output logic [15:0] chmask,
                            output int dcyc);
        nsp = 0; chmask = '0; dcyc = -1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (spike_valid && spike_ready) begin
                nsp++;
                chmask[spike_ch] = 1'b1;
            end
            if (sweep_done) dcyc = c;
            if (dcyc >= 0 && c > dcyc) break;
            step();
        end
        if (dcyc < 0) chk("sweep_timeout", 32'(dcyc), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        step();
    endtask

    int          nsp, dcyc;
    logic [15:0] mask;
    int          exp_pot [5];
    int          exp_sp  [5];

    initial begin
        exp_pot = '{191, 126, 61, 252, 187};
        exp_sp  = '{0, 1, 1, 0, 1};
        rst = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_w = '0; chan_en = 4'hF; spike_ready = 1'b1;
        step(); step();
        chk("rst_valid", 32'(spike_valid), 32'd0);
        chk("rst_ch",    32'(spike_ch),    32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(sweep_done), 32'd0);
        chk("rst_ovr",   32'(overrun),     32'd0);
        rst = 1'b1;
        step();

        // Single-channel integer spike pattern
        wr(2'd0, 8'd191);
        for (int k = 0; k < 5; k++) begin
            do_sweep(nsp, mask, dcyc);
            chk($sformatf("t%0d_pot0", k + 1), 32'(dut.pot[0]),
                32'(exp_pot[k]));
            chk($sformatf("t%0d_nspk", k + 1), 32'(nsp), 32'(exp_sp[k]));
            chk($sformatf("t%0d_mask", k + 1), 32'(mask),
                32'(exp_sp[k]));
            if (k == 0) chk("done_cycle", 32'(dcyc), 32'd5);
        end

        // Stall: preload pot[1]=pot[2]=1, then weights 255
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd1);
        wr(2'd2, 8'd1);
        do_sweep(nsp, mask, dcyc);
        chk("pre_pot1", 32'(dut.pot[1]), 32'd1);
        chk("pre_pot2", 32'(dut.pot[2]), 32'd1);
        wr(2'd1, 8'd255);
        wr(2'd2, 8'd255);
        spike_ready = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall%0d_v", i), 32'(spike_valid), 32'd1);
            chk($sformatf("stall%0d_ch", i), 32'(spike_ch), 32'd1);
            chk($sformatf("stall%0d_p2", i), 32'(dut.pot[2]), 32'd1);
            step();
        end
        chk("acc_ch1", 32'(spike_ch), 32'd1);
        spike_ready = 1'b1;
        step();
        chk("next_v",  32'(spike_valid), 32'd1);
        chk("next_ch", 32'(spike_ch), 32'd2);
        chk("p2_after", 32'(dut.pot[2]), 32'd0);
        step();
        chk("stall_done", 32'(sweep_done), 32'd1);
        chk("drained", 32'(spike_valid), 32'd0);
        step();
        chk("stall_idle", 32'(busy), 32'd0);

        // Overrun: tick at T and T+2
        chk("ovr_pre", 32'(overrun), 32'd0);
        tick = 1'b1; step();
        tick = 1'b0; step();
        tick = 1'b1;
        chk("ovr_t2", 32'(overrun), 32'd0);
        step();
        tick = 1'b0;
        chk("ovr_t3", 32'(overrun), 32'd1);
        step();
        chk("ovr_t4_done", 32'(sweep_done), 32'd0);
        step();
        chk("ovr_t5_done", 32'(sweep_done), 32'd1);
        step();
        chk("ovr_t6_busy", 32'(busy), 32'd0);
        step();
        chk("ovr_t7_busy", 32'(busy), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Enable mask from a clean state
        rst = 1'b0; step(); rst = 1'b1; step();
        chk("ovr_cleared", 32'(overrun), 32'd0);
        for (int c = 0; c < 4; c++) wr(2'(c), 8'd200);
        chan_en = 4'b0101;
        do_sweep(nsp, mask, dcyc);
        chk("mask1_nspk", 32'(nsp), 32'd0);
        do_sweep(nsp, mask, dcyc);
        chk("mask2_nspk", 32'(nsp), 32'd2);
        chk("mask2_chs",  32'(mask), 32'h5);
        chk("mask_pot0",  32'(dut.pot[0]), 32'd144);
        chk("mask_pot1",  32'(dut.pot[1]), 32'd0);
        chk("mask_pot3",  32'(dut.pot[3]), 32'd0);

        // Config collision: rewrite wt[2] while channel 2 is visited
        chan_en = 4'hF;
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        wr(2'd3, 8'd0);
        wr(2'd2, 8'd100);
        tick = 1'b1; step();
        tick = 1'b0; step();
        step();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_w = 8'd10;
        step();
        cfg_we = 1'b0;
        wait_idle("coll_idle");
        chk("coll_pot2_a", 32'(dut.pot[2]), 32'd244);
        chk("coll_wt2",    32'(dut.wt[2]), 32'd10);
        do_sweep(nsp, mask, dcyc);
        chk("coll_pot2_b", 32'(dut.pot[2]), 32'd254);

        // Reset mid-sweep with a pending spike
        wr(2'd2, 8'd255);
        spike_ready = 1'b0;
        tick = 1'b1; step();
        tick = 1'b0; step();
        step(); step();
        chk("mid_v", 32'(spike_valid), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(spike_valid), 32'd0);
        chk("mrst_ch",    32'(spike_ch), 32'd0);
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(sweep_done), 32'd0);
        chk("mrst_pot2",  32'(dut.pot[2]), 32'd0);
        step();
        rst = 1'b1;
        spike_ready = 1'b1;
        step();
        do_sweep(nsp, mask, dcyc);
        chk("post_nspk", 32'(nsp), 32'd0);
        chk("post_pot2", 32'(dut.pot[2]), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_sched.md
# neuron_sched

Time-multiplexed accumulate-and-fire scheduler that shares one overflow-accumulator datapath among `CHANNELS` rate-divider neurons. On every `tick` it sweeps all channels in order and adds each channel's weight to that channel's membrane potential. An overflow emits a spike event on a valid/ready output. The block sits between the host/JTAG weight-configuration path and the downstream spike consumer, and replaces per-channel divider instances.

## Interface
- `WIDTH`, 8: weight and membrane-potential width.
- `CHANNELS`, 4: neuron count, 2..16.
- `CH_W`, `$clog2(CHANNELS)`: channel index width (derived).

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `tick` input 1: sweep request pulse.
- `cfg_we` input 1: weight write strobe.
- `cfg_addr` input `CH_W`: weight write channel.
- `cfg_w` input `WIDTH`: weight write data.
- `chan_en` input `CHANNELS`: per-channel enable, sampled when the channel is visited.
- `spike_valid` output 1: spike event pending.
- `spike_ch` output `CH_W`: channel of the pending spike.
- `spike_ready` input 1: consumer accepts the event.
- `busy` output 1: sweep in progress.
- `sweep_done` output 1: one-cycle pulse at sweep end.
- `overrun` output 1: sticky flag; a tick arrived while busy.

## Operation
- State storage:
  - `pot[CHANNELS]` holds `WIDTH`-bit potentials.
  - `wt[CHANNELS]` holds `WIDTH`-bit weights.
  - The FSM has states IDLE, RUN, DONE.
  - A channel pointer `ptr` tracks the current channel.
- IDLE:
  - `tick` moves the FSM to RUN with `ptr`=0.
- RUN:
  - Each cycle, the FSM processes channel `ptr`, unless stalled.
  - Enabled channel: `{carry, sum} = pot[ptr] + wt[ptr]` in `WIDTH+1` bits; `pot[ptr] <= sum`.
  - `carry`=1 loads the output register: `spike_valid`<=1, `spike_ch`<=`ptr`.
  - Disabled channel: visited for one cycle with no update and no spike.
  - After `ptr`=`CHANNELS-1`, the FSM moves to DONE.
- Stall: in RUN, while `spike_valid`=1 and `spike_ready`=0, no channel is processed and `ptr` holds.
  - The output register is single-entry, so no spike is ever dropped.
- DONE:
  - `sweep_done`=1 for one cycle.
  - The FSM returns to IDLE.
  - DONE does not wait for the final spike to drain.
- Handshake:
  - The event transfers on `spike_valid & spike_ready`.
  - If a new spike is produced in the transfer cycle, `spike_valid` stays 1 and carries the new channel.
  - `spike_valid` and `spike_ch` are stable until accepted.
- Config:
  - `cfg_we` writes `wt[cfg_addr]` in any state.
  - A write to the channel processed in the same cycle is not used for that visit; the old weight applies.
  - `cfg_addr` ≥ `CHANNELS` is ignored.
- Tick handling:
  - A `tick` while `busy`=1 (RUN or DONE) is dropped and sets `overrun`.
  - `overrun` clears only on reset.
  - A `tick` in the same cycle as the DONE→IDLE transition is also dropped.
- Arithmetic: modulo 2^`WIDTH`. Spike is equivalent to `pot_new < wt`.

## Timing
- Reset values:
  - Outputs: `spike_valid`=0, `spike_ch`=0, `busy`=0, `sweep_done`=0, `overrun`=0.
  - Internal state: all `pot`=0, all `wt`=0, FSM in IDLE.
- `tick` sampled at edge T:
  - `busy`=1 from T+1.
  - Channel 0 is processed in cycle T+1.
- A spike from the channel processed in cycle C is visible on `spike_valid` from C+1.
- An unstalled sweep takes `CHANNELS` RUN cycles plus 1 DONE cycle.
  - `busy` is high for `CHANNELS+1` cycles.
  - `sweep_done` is high in the last of those cycles.
- Reset mid-sweep:
  - Immediate return to IDLE.
  - Pending spike discarded.
  - Potentials and weights cleared.

## Configuration
- Macro `NEURON_SCHED_LEAK_EN`.
- Defined: leaky update `pot_new = pot - (pot >> 3) + wt`.
  - The subtraction never underflows.
  - Carry is taken from the `WIDTH+1`-bit add.
  - Disabled channels still do not change.
- Undefined: pure accumulate, exactly as in Operation.

## Test plan
- Single channel, integer spike pattern: `wt[0]`=191, others 0, `spike_ready`=1, 5 ticks.
  - `pot[0]` = 191, 126, 61, 252, 187.
  - Spikes on ticks 2, 3 and 5, each with `spike_ch`=0.
- Stall: `wt[1]`=`wt[2]`=255 with `pot[1]`=`pot[2]`=1 preloaded by earlier sweeps, `spike_ready`=0 for 4 cycles.
  - Channel 1 event held stable.
  - Channel 2 not processed until acceptance.
  - Sweep then completes; no event is lost.
- Overrun: `tick` at T and again at T+2 with `CHANNELS`=4.
  - `overrun`=1 from T+3.
  - Exactly one sweep runs; `sweep_done` at T+5.
- Enable mask: `chan_en`=4'b0101, all weights 200, 2 ticks.
  - Only channels 0 and 2 spike, on tick 2.
  - `pot[1]`=`pot[3]`=0.
- Config collision: write `wt[2]`=10 in the cycle channel 2 is processed, with old `wt[2]`=100.
  - That visit adds 100; the next sweep adds 10.
- Reset mid-sweep: assert `rst`=0 while `spike_valid`=1 in RUN.
  - All outputs go to 0 immediately.
  - Next `tick` starts from `pot`=0 and `wt`=0, so no spikes.
